// File: rtl/result_disp_pkg.sv
// Shared types and constants for the result BCD display: FSM states,
// active-low seven-segment codes (gfedcba) and the decimal display limit.
package result_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam int         MAX_DEC   = 999999;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        return (digit > 4'd9) ? SEG_BLANK : SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/result_bcd_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blank
// override; non-decimal codes also show blank.
module seg7_decode
    import result_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg_of(digit);
    end

endmodule

// File: rtl/result_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter driving six latched HEX
// displays. Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits.
module result_bcd_display
    import result_disp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 6,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    localparam int BCD_W = 4 * DIGITS;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    overflow_q, overflow_d;
    logic                    done_q, done_d;
    logic [DIGITS-1:0][6:0]  hex_q, hex_d, seg_w;
    logic [DIGITS-1:0]       lead_blank;

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        logic seen_nz;
        seen_nz       = 1'b0;
        lead_blank    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen_nz       = seen_nz | (bcd_q[4*i +: 4] != 4'd0);
            lead_blank[i] = ~seen_nz;
        end
    end
`else
    always_comb begin
        lead_blank = '0;
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .digit (bcd_q[4*g +: 4]),
            .blank (lead_blank[g]),
            .seg   (seg_w[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        hex_d      = hex_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d    = in_data;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                // A set top bit would carry out of the sixth decimal digit.
                if (bcd_adj[BCD_W-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                hex_d      = ovf_q ? {DIGITS{SEG_DASH}} : seg_w;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            hex_q      <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            hex_q      <= hex_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display; expected displays come from a
// decimal reference model (honours LEAD_ZERO_BLANK_EN when defined).
module tb_result_bcd_display;
    import result_disp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, busy, done, overflow;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hex_obs;

    result_bcd_display dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    always #5 clk = ~clk;

    assign hex_obs = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          dones    = 0;
    logic [41:0] shown;

    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    function automatic logic [41:0] model_hex(input logic [31:0] v);
        logic [41:0] r;
        longint      lv;
        longint      p;
        logic        blank;
        lv = longint'(v);
        p  = 1;
        r  = '0;
        for (int i = 0; i < 6; i++) begin
            blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
            blank = (i > 0) && (lv < p);
`endif
            if (lv > longint'(MAX_DEC)) r[7*i +: 7] = 7'h3F;
            else if (blank)             r[7*i +: 7] = 7'h7F;
            else                        r[7*i +: 7] = seg_code(int'((lv / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        logic        acc;
        logic        rs;
        logic [31:0] d;
        exp_t        e;
        acc = in_valid && in_ready && rst_n;
        rs  = rst_n;
        d   = in_data;
        @(posedge clk);
        #1;
        cycle++;
        if (!rs) begin
            sb.delete();
            shown = ALL_BLANK;
        end else if (acc) begin
            sb.push_back('{model_hex(d), (longint'(d) > longint'(MAX_DEC)), cycle});
        end
        if (done) begin
            dones++;
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("hex", hex_obs, e.hex);
                check_eq("overflow", overflow, e.ovf);
                check_eq("latency", cycle - e.acc, 33);
            end
            shown = hex_obs;
        end else if (busy) begin
            check_eq("hex_hold", hex_obs, shown);
        end
    endtask

    task automatic wait_done();
        int start;
        start = dones;
        for (int i = 0; i < 100 && dones == start; i++) tick();
        check_eq("done_seen", dones != start, 1);
    endtask

    task automatic send(input logic [31:0] v);
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic convert(input logic [31:0] v);
        send(v);
        wait_done();
    endtask

    initial begin
        int saved;
        shown = ALL_BLANK;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_hex", hex_obs, ALL_BLANK);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overflow", overflow, 0);

        convert(32'd123456);
        check_eq("hex_123456", hex_obs, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        convert(32'd999999);
        check_eq("hex_999999", hex_obs, {6{7'h10}});
        convert(32'd1000000);
        check_eq("ovf_1000000", overflow, 1);
        convert(32'hFFFFFFFF);
        convert(32'd42);
        check_eq("ovf_cleared", overflow, 0);
        convert(32'd0);
        convert(32'd305);

        // Request during conversion must be ignored.
        send(32'd123);
        repeat (5) tick();
        in_valid = 1'b1;
        in_data  = 32'd5;
        tick();
        in_valid = 1'b0;
        wait_done();
        repeat (40) tick();

        // Reset in the middle of a conversion.
        send(32'd777);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        saved = dones;
        check_eq("abort_hex", hex_obs, ALL_BLANK);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_overflow", overflow, 0);
        repeat (40) tick();
        check_eq("abort_no_done", dones, saved);

        // Back-to-back: new value held and accepted in the done cycle.
        in_valid = 1'b1;
        in_data  = 32'd111;
        tick();
        in_data  = 32'd222;
        saved    = dones;
        for (int i = 0; i < 100 && dones == saved; i++) tick();
        check_eq("b2b_done", done, 1);
        check_eq("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_done();
        repeat (40) tick();
        check_eq("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
